// File: rtl/mem_pkg.sv
// Shared types and constants for the memory/UART arbiter: FSM states, UART
// register addresses, bus-control levels and status-word bit positions.
package mem_pkg;

   typedef enum logic [3:0] {
      IDLE, SRD, SWR_SETUP, SWR_PULSE, SWR_HOLD,
      URD_WAIT, URD, UWR, UWR_WAIT, DONE
   } state_t;

   localparam logic [15:0] UART_DATA_DFLT = 16'hBF00;
   localparam logic [15:0] UART_STAT_DFLT = 16'hBF01;

   localparam int STAT_RX_BIT = 1;
   localparam int STAT_TX_BIT = 0;

   typedef struct packed {
      logic en;
      logic oe;
      logic we;
      logic rdn;
      logic wrn;
      logic drive;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{en: 1'b1, oe: 1'b1, we: 1'b1,
                                 rdn: 1'b1, wrn: 1'b1, drive: 1'b0};

   // Control levels that hold for the whole of a state; registered from the next state.
   function automatic ctl_t ctl_of(state_t s);
      ctl_t c;
      c = CTL_IDLE;
      case (s)
         SRD:                 begin c.en = 1'b0; c.oe = 1'b0; end
         SWR_SETUP, SWR_HOLD: begin c.en = 1'b0; c.drive = 1'b1; end
         SWR_PULSE:           begin c.en = 1'b0; c.we = 1'b0; c.drive = 1'b1; end
         URD:                 c.rdn = 1'b0;
         UWR:                 begin c.wrn = 1'b0; c.drive = 1'b1; end
         default:             ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side handshake of the arbiter: fetch port, data port and pipeline stall.
interface mem_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int VA_W   = 16
);
   logic              IfReq;
   logic [VA_W-1:0]   IfAddr;
   logic [DATA_W-1:0] IfData;
   logic              IfValid;
   logic              MemRead2;
   logic              MemWrite2;
   logic [VA_W-1:0]   Addr;
   logic [DATA_W-1:0] DataIn;
   logic [DATA_W-1:0] DataOut;
   logic              MemDone;
   logic              Pause;

   modport master (
      output IfReq, IfAddr, MemRead2, MemWrite2, Addr, DataIn,
      input  IfData, IfValid, DataOut, MemDone, Pause
   );

   modport slave (
      input  IfReq, IfAddr, MemRead2, MemWrite2, Addr, DataIn,
      output IfData, IfValid, DataOut, MemDone, Pause
   );
endinterface

// File: rtl/ram_bus_drv.sv
// Tri-state driver for the shared SRAM/UART data bus plus the registered
// capture of read data into the data-port and fetch-port result registers.
module ram_bus_drv #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              drive,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              cap_data,
   input  logic              cap_if,
   input  logic              cap_byte,
   input  logic              ld_stat,
   input  logic [DATA_W-1:0] stat_word,
   output logic [DATA_W-1:0] data_q,
   output logic [DATA_W-1:0] if_q,
   inout  wire  [DATA_W-1:0] bus
);

   logic [DATA_W-1:0] bus_word;

   assign bus = drive ? wr_data : {DATA_W{1'bz}};

   // The UART only returns a byte; the upper lanes of the bus are not trusted.
   always_comb begin
      bus_word = bus;
      if (cap_byte) bus_word = {{(DATA_W-8){1'b0}}, bus[7:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         if_q   <= '0;
      end else begin
         if (ld_stat)       data_q <= stat_word;
         else if (cap_data) data_q <= bus_word;
         if (cap_if)        if_q   <= bus_word;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-SRAM plus memory-mapped UART access controller shared by instruction
// fetch and the MEM stage; data accesses win, and Pause stalls the pipeline.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int              DATA_W         = 16,
   parameter int              VA_W           = 16,
   parameter int              ADDR_W         = 18,
   parameter int              WAIT_CYCLES    = 1,
   parameter logic [VA_W-1:0] UART_DATA_ADDR = VA_W'(UART_DATA_DFLT),
   parameter logic [VA_W-1:0] UART_STAT_ADDR = VA_W'(UART_STAT_DFLT)
) (
   input  logic              Clk,
   input  logic              Rst,
   mem_arbiter_if.slave      cpu,
   output logic              Ram_EN,
   output logic              Ram_OE,
   output logic              Ram_WE,
   output logic [ADDR_W-1:0] Ram_address,
   inout  wire  [DATA_W-1:0] Ram_data,
   output logic              rdn,
   output logic              wrn,
   input  logic              data_ready,
   input  logic              tbre,
   input  logic              tsre
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1) + 1;

   state_t            state, nxt;
   ctl_t              ctl;
   logic [CNT_W-1:0]  cnt;
   logic              is_data;
   logic [DATA_W-1:0] wdata_q;
   logic              mem_done, if_valid;
   logic              data_req, hit_uart, hit_stat, strobe_end;
   logic              drive, cap_data, cap_if, cap_byte, ld_stat;
   logic [DATA_W-1:0] bus_wdata, stat_word, data_q, if_q;

   assign data_req   = cpu.MemRead2 | cpu.MemWrite2;
   assign hit_uart   = (cpu.Addr == UART_DATA_ADDR);
   assign hit_stat   = (cpu.Addr == UART_STAT_ADDR);
   assign strobe_end = (cnt == '0);

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (data_req) begin
               if (hit_uart)      nxt = cpu.MemWrite2 ? UWR : URD_WAIT;
               else if (hit_stat) nxt = DONE;
               else               nxt = cpu.MemWrite2 ? SWR_SETUP : SRD;
            end else if (cpu.IfReq) begin
               nxt = SRD;
            end
         end
         SRD:       if (strobe_end) nxt = DONE;
         SWR_SETUP: nxt = SWR_PULSE;
         SWR_PULSE: if (strobe_end) nxt = SWR_HOLD;
         SWR_HOLD:  nxt = DONE;
         URD_WAIT:  if (data_ready) nxt = URD;
         URD:       if (strobe_end) nxt = DONE;
         UWR:       if (strobe_end) nxt = UWR_WAIT;
         UWR_WAIT:  if (tbre & tsre) nxt = DONE;
         DONE:      nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   // Strobe counter reloads on every state change, so each timed state lasts WAIT_CYCLES+1.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state       <= IDLE;
         ctl         <= CTL_IDLE;
         cnt         <= '0;
         is_data     <= 1'b0;
         wdata_q     <= '0;
         Ram_address <= '0;
         mem_done    <= 1'b0;
         if_valid    <= 1'b0;
      end else begin
         state <= nxt;
         ctl   <= ctl_of(nxt);
         if (nxt != state)       cnt <= CNT_W'(WAIT_CYCLES);
         else if (!strobe_end)   cnt <= cnt - CNT_W'(1);
         if (state == IDLE && nxt != IDLE) begin
            is_data     <= data_req;
            wdata_q     <= cpu.DataIn;
            Ram_address <= data_req ? ADDR_W'(cpu.Addr) : ADDR_W'(cpu.IfAddr);
         end
         mem_done <= (nxt == DONE) && ((state == IDLE) || is_data);
         if_valid <= (nxt == DONE) && (state != IDLE) && !is_data;
      end
   end

   always_comb begin
      stat_word              = '0;
      stat_word[STAT_RX_BIT] = data_ready;
      stat_word[STAT_TX_BIT] = tbre & tsre;
   end

   assign drive     = ctl.drive;
   assign bus_wdata = (state == UWR) ? {{(DATA_W-8){1'b0}}, wdata_q[7:0]} : wdata_q;
   assign cap_data  = strobe_end && ((state == SRD && is_data) || state == URD);
   assign cap_if    = strobe_end && state == SRD && !is_data;
   assign cap_byte  = (state == URD);
   assign ld_stat   = (state == IDLE) && data_req && !cpu.MemWrite2 && !hit_uart && hit_stat;

   ram_bus_drv #(.DATA_W(DATA_W)) u_drv (
      .clk       (Clk),
      .rst       (Rst),
      .drive     (drive),
      .wr_data   (bus_wdata),
      .cap_data  (cap_data),
      .cap_if    (cap_if),
      .cap_byte  (cap_byte),
      .ld_stat   (ld_stat),
      .stat_word (stat_word),
      .data_q    (data_q),
      .if_q      (if_q),
      .bus       (Ram_data)
   );

   assign Ram_EN      = ctl.en;
   assign Ram_OE      = ctl.oe;
   assign Ram_WE      = ctl.we;
   assign rdn         = ctl.rdn;
   assign wrn         = ctl.wrn;
   assign cpu.DataOut = data_q;
   assign cpu.IfData  = if_q;
   assign cpu.MemDone = mem_done;
   assign cpu.IfValid = if_valid;
   assign cpu.Pause   = (data_req & ~mem_done) | (cpu.IfReq & ~if_valid);

endmodule
